// File: rtl/seq_mult_unit_if.sv
// Operand/result bundle for seq_mult_unit: request side (start, operands) and
// status/result side (busy, done, product halves).
interface seq_mult_unit_if #(
    parameter int size = 16
);
    logic            start;
    logic            signed_op;
    logic [size-1:0] a;
    logic [size-1:0] b;
    logic            busy;
    logic            done;
    logic [size-1:0] result_lo;
    logic [size-1:0] result_hi;

    modport master (
        output start, signed_op, a, b,
        input  busy, done, result_lo, result_hi
    );

    modport slave (
        input  start, signed_op, a, b,
        output busy, done, result_lo, result_hi
    );
endinterface

// File: rtl/seq_mult_unit.sv
// Sequential shift-and-add multiplier, signed or unsigned, one multiplier bit per cycle.
// Optional macro EARLY_TERM_EN ends the run once the remaining multiplier bits are all zero.
module seq_mult_unit #(
    parameter int size = 16
) (
    input logic          clk,
    input logic          reset_n,
    seq_mult_unit_if.slave bus
);
    localparam int PW = 2 * size;
    localparam int CW = (size > 1) ? $clog2(size) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(size - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   mcand;
    logic [size-1:0] mplier;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   count;
    logic            sign;
    logic [PW-1:0]   result;

    logic            load;
    logic            step;
    logic            finish;
    logic            busy;
    logic            done;
    logic            last_iter;
    logic [size-1:0] mplier_shift;
    logic [PW-1:0]   acc_sum;
    logic [PW-1:0]   product;

    // The most negative operand maps to 1 followed by zeros, which is still the
    // correct magnitude when read back as an unsigned size-bit value.
    function automatic logic [size-1:0] magnitude(input logic [size-1:0] v, input logic sgn);
        return (sgn && v[size-1]) ? (~v + size'(1)) : v;
    endfunction

    assign mplier_shift = mplier >> 1;
    assign acc_sum      = acc + (mplier[0] ? mcand : '0);
    assign product      = sign ? (~acc_sum + PW'(1)) : acc_sum;

`ifdef EARLY_TERM_EN
    assign last_iter = (mplier_shift == '0) || (count == LAST_COUNT);
`else
    assign last_iter = (count == LAST_COUNT);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_iter) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The final iteration's partial sum goes straight into the result register,
    // so the product is visible in the same cycle done is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            sign   <= 1'b0;
            result <= '0;
        end else if (load) begin
            mcand  <= {{size{1'b0}}, magnitude(bus.a, bus.signed_op)};
            mplier <= magnitude(bus.b, bus.signed_op);
            acc    <= '0;
            count  <= '0;
            sign   <= bus.signed_op & (bus.a[size-1] ^ bus.b[size-1]);
        end else if (step) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier_shift;
            count  <= count + CW'(1);
            if (finish) begin
                result <= product;
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.result_lo = result[size-1:0];
    assign bus.result_hi = result[PW-1:size];
endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed self-checking bench for seq_mult_unit; edge counts treat the start edge as edge 1,
// so a full-length run shows done on edge size+1.
module tb_seq_mult_unit;
    localparam int size = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seq_mult_unit_if #(.size(size)) bus ();

    seq_mult_unit #(.size(size)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] hi;
        logic [15:0] lo;
        int          lat_early;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic int expLatency(input int lat_early);
`ifdef EARLY_TERM_EN
        return lat_early;
`else
        return 17;
`endif
    endfunction

    task automatic applyStimulus(input logic s, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.signed_op = s;
        bus.a         = a;
        bus.b         = b;
    endtask

    // Returns at the negedge where done is first seen high (or after the budget expires).
    task automatic runOp(input logic s, input logic [15:0] a, input logic [15:0] b, output int edges);
        applyStimulus(s, a, b);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    initial begin
        int   edges;
        int   edges2;
        int   done_count;
        logic busy_all;

        vecs[0] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 17};
        vecs[1] = '{1'b1, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 17};
        vecs[2] = '{1'b1, 16'hFFFD, 16'h0007, 16'hFFFF, 16'hFFEB, 4};
        vecs[3] = '{1'b0, 16'h1234, 16'h0003, 16'h0000, 16'h369C, 3};
        vecs[4] = '{1'b0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 2};
        vecs[5] = '{1'b1, 16'h0005, 16'hFFFE, 16'hFFFF, 16'hFFF6, 3};
        vecs[6] = '{1'b1, 16'h7FFF, 16'h8000, 16'hC000, 16'h8000, 17};
        vecs[7] = '{1'b0, 16'h00FF, 16'h0100, 16'h0000, 16'hFF00, 10};

        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        #1;
        checkOutput("reset_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("reset_done", {63'd0, bus.done}, 64'd0);
        checkOutput("reset_result", {32'd0, bus.result_hi, bus.result_lo}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            runOp(vecs[i].s, vecs[i].a, vecs[i].b, edges);
            checkOutput($sformatf("v%0d_latency", i), 64'(edges), 64'(expLatency(vecs[i].lat_early)));
            checkOutput($sformatf("v%0d_result", i), {32'd0, bus.result_hi, bus.result_lo},
                        {32'd0, vecs[i].hi, vecs[i].lo});
            @(negedge clk);
            checkOutput($sformatf("v%0d_done_pulse", i), {62'd0, bus.done, bus.busy}, 64'd0);
            checkOutput($sformatf("v%0d_hold", i), {32'd0, bus.result_hi, bus.result_lo},
                        {32'd0, vecs[i].hi, vecs[i].lo});
        end

        // start held high with changing operands while busy must not disturb the run
        applyStimulus(1'b0, 16'h0011, 16'h0003);
        @(posedge clk);
        edges    = 1;
        busy_all = 1'b1;
        @(negedge clk);
        while (!bus.done && edges < 100) begin
            busy_all      = busy_all & bus.busy;
            bus.a         = 16'h0100 + 16'(edges);
            bus.b         = 16'h7000 - 16'(edges);
            bus.signed_op = edges[0];
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        checkOutput("ignore_busy_held", {63'd0, busy_all}, 64'd1);
        checkOutput("ignore_latency", 64'(edges), 64'(expLatency(3)));
        checkOutput("ignore_result", {32'd0, bus.result_hi, bus.result_lo}, 64'h33);
        done_count = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) done_count++;
        end
        checkOutput("ignore_single_done", 64'(done_count), 64'd0);

        // back-to-back: second start lands in the single idle cycle after done
        runOp(1'b0, 16'h0002, 16'hFFFF, edges);
        checkOutput("b2b_first_result", {32'd0, bus.result_hi, bus.result_lo}, 64'h0001FFFE);
        runOp(1'b0, 16'h0003, 16'h8001, edges2);
        checkOutput("b2b_second_result", {32'd0, bus.result_hi, bus.result_lo}, 64'h00018003);
        checkOutput("b2b_gap", 64'(edges2 + 1), 64'(expLatency(17) + 1));
        @(negedge clk);

        // reset mid-run aborts the multiply and clears outputs at once
        applyStimulus(1'b0, 16'hFFFF, 16'hFFFF);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("abort_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("abort_done", {63'd0, bus.done}, 64'd0);
        checkOutput("abort_result", {32'd0, bus.result_hi, bus.result_lo}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        done_count = 0;
        busy_all   = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) done_count++;
            busy_all = busy_all | bus.busy;
        end
        checkOutput("abort_no_done", 64'(done_count), 64'd0);
        checkOutput("abort_idle", {63'd0, busy_all}, 64'd0);
        runOp(1'b0, 16'h0003, 16'h0005, edges);
        checkOutput("abort_next_latency", 64'(edges), 64'(expLatency(4)));
        checkOutput("abort_next_result", {32'd0, bus.result_hi, bus.result_lo}, 64'h0000000F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
